// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master data memory port arbiter.
// Holds the state encodings and the default address/data widths.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 30;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick.
// last = index granted most recently; on a tie the other master wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two masters onto one single-cycle data memory port.
// state  | meaning
// IDLE   | waiting for a request; the winner's request is latched here
// ACCESS | latched request drives the memory for one cycle
// RESP   | one-cycle ack to the winner, then back to IDLE
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              last;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              lat_idx;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  rr_pick2 u_pick (
    .req0      (m0_req),
    .req1      (m1_req),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (gnt_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // mem strobes are gated by reset so an interrupted access never commits
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    if (state == ST_ACCESS) begin
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_read  = ~lat_we & ~reset;
      mem_write = lat_we & ~reset;
    end
    if (state == ST_RESP) begin
      m0_ack = ~lat_idx;
      m1_ack = lat_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= 1'b1;
      lat_idx   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      if (state == ST_IDLE && gnt_valid) begin
        last      <= gnt_idx;
        lat_idx   <= gnt_idx;
        lat_we    <= gnt_idx ? m1_we    : m0_we;
        lat_addr  <= gnt_idx ? m1_addr  : m0_addr;
        lat_wdata <= gnt_idx ? m1_wdata : m0_wdata;
      end
      if (state == ST_ACCESS && !lat_we) begin
        if (lat_idx) begin
          m1_rdata <= mem_rdata;
        end else begin
          m0_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 64-word behavioural memory.
// Addresses at or above 64 read back as zero.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              m0_req, m1_req;
  logic              m0_we, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ack, m1_ack;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] ram [0:63];
  logic              mem_init;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 64) ? ram[mem_addr[5:0]] : '0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
      ram[3]  <= 32'h0000_004F;
      ram[4]  <= 32'h0000_0066;
      ram[11] <= 32'h0000_1111;
      ram[20] <= 32'h1234_5678;
    end else if (mem_write && mem_addr < 64) begin
      ram[mem_addr[5:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_ack;
  int prev_c;
  logic exp_idx;

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    tick();
    mem_init = 1'b0;
    tick();
    tick();
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_mem_rd_wr", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    reset = 1'b0;
    tick();

    // simultaneous reads after reset: m0 wins the first tie
    m0_req = 1; m0_we = 0; m0_addr = 3;
    m1_req = 1; m1_we = 0; m1_addr = 4;
    tick();
    chk("tie_access_read", {mem_read, mem_write}, 2'b10);
    chk("tie_access_addr", mem_addr, 3);
    tick();
    chk("tie_m0_ack", {m0_ack, m1_ack}, 2'b10);
    chk("tie_m0_rdata", m0_rdata, 32'h4F);
    m0_req = 0;
    tick();
    chk("tie_gap1_ack", {m0_ack, m1_ack}, 0);
    tick();
    chk("tie_m1_access_addr", mem_addr, 4);
    tick();
    chk("tie_m1_ack", {m0_ack, m1_ack}, 2'b01);
    chk("tie_m1_rdata", m1_rdata, 32'h66);
    m1_req = 0;
    tick();

    // m0 write, then m1 read-back of the same word
    m0_req = 1; m0_we = 1; m0_addr = 16; m0_wdata = 32'hDEADBEEF;
    tick();
    chk("wr_access_strobes", {mem_read, mem_write}, 2'b01);
    chk("wr_access_addr", mem_addr, 16);
    chk("wr_access_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_m0_ack", {m0_ack, m1_ack}, 2'b10);
    chk("wr_write_one_cycle", mem_write, 0);
    chk("wr_keeps_rdata", m0_rdata, 32'h4F);
    m0_req = 0;
    tick();
    m1_req = 1; m1_we = 0; m1_addr = 16;
    tick();
    tick();
    chk("rb_m1_ack", {m0_ack, m1_ack}, 2'b01);
    chk("rb_m1_rdata", m1_rdata, 32'hDEADBEEF);
    m1_req = 0;
    tick();

    // m0 changes its request while the access is in flight
    m0_req = 1; m0_we = 1; m0_addr = 10; m0_wdata = 32'h0000_AAAA;
    tick();
    m0_addr = 11; m0_wdata = 32'h0000_BBBB;
    #1;
    chk("chg_access_addr", mem_addr, 10);
    chk("chg_access_wdata", mem_wdata, 32'h0000_AAAA);
    tick();
    chk("chg_m0_ack", m0_ack, 1);
    m0_req = 0;
    tick();
    chk("chg_ram10", ram[10], 32'h0000_AAAA);
    chk("chg_ram11", ram[11], 32'h0000_1111);

    // out-of-range read completes with zero data
    m1_req = 1; m1_we = 0; m1_addr = 30'h100;
    tick();
    chk("oor_addr_passthru", mem_addr, 30'h100);
    tick();
    chk("oor_m1_ack", {m0_ack, m1_ack}, 2'b01);
    chk("oor_m1_rdata", m1_rdata, 0);
    m1_req = 0;
    tick();

    // both masters hold requests: grants must alternate starting with m0
    m0_req = 1; m0_we = 0; m0_addr = 3;
    m1_req = 1; m1_we = 0; m1_addr = 4;
    n_ack = 0; prev_c = 0; exp_idx = 1'b0;
    for (int c = 0; c < 40 && n_ack < 6; c++) begin
      tick();
      chk("rr_ack_exclusive", m0_ack & m1_ack, 0);
      if (m0_ack || m1_ack) begin
        chk("rr_grant_idx", m1_ack, exp_idx);
        chk("rr_rdata", m1_ack ? m1_rdata : m0_rdata, m1_ack ? 32'h66 : 32'h4F);
        if (n_ack > 0) chk("rr_interval", c - prev_c, 3);
        prev_c = c;
        exp_idx = ~exp_idx;
        n_ack++;
      end
    end
    chk("rr_ack_count", n_ack, 6);
    m0_req = 0; m1_req = 0;
    tick();

    // reset during an m1 write aborts it
    m1_req = 1; m1_we = 1; m1_addr = 20; m1_wdata = 32'h0000_5555;
    tick();
    chk("abort_pre_write", mem_write, 1);
    reset = 1'b1;
    #1;
    chk("abort_write_gated", mem_write, 0);
    tick();
    chk("abort_no_ack", {m0_ack, m1_ack}, 0);
    chk("abort_ram20", ram[20], 32'h1234_5678);
    reset = 1'b0; m1_req = 0;
    #1;
    chk("abort_idle_strobes", {mem_read, mem_write}, 0);
    tick();
    chk("abort_idle_ack", {m0_ack, m1_ack}, 0);
    chk("abort_rdata_cleared", m0_rdata, 0);
    chk("abort_ram20_after", ram[20], 32'h1234_5678);

    // pointer is back at m1, so m0 wins the next tie
    m0_req = 1; m0_we = 0; m0_addr = 3;
    m1_req = 1; m1_we = 0; m1_addr = 4;
    tick();
    chk("post_rst_tie_addr", mem_addr, 3);
    tick();
    chk("post_rst_tie_ack", {m0_ack, m1_ack}, 2'b10);
    m0_req = 0; m1_req = 0;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word-address width matching the data memory Address port.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports m0_req, m1_req  input  1 each  access request, held high until the matching ack.
REQ-006 SHALL have ports m0_we, m1_we  input  1 each  1 = write, 0 = read; stable while req is high.
REQ-007 SHALL have ports m0_addr, m1_addr  input  ADDR_W each  word address; stable while req is high.
REQ-008 SHALL have ports m0_wdata, m1_wdata  input  DATA_W each  write data; stable while req is high.
REQ-009 SHALL have ports m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have ports m0_rdata, m1_rdata  output  DATA_W each  registered read result, valid in the ack cycle.
REQ-011 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_read  output  1, mem_write  output  1  drive the data memory.
REQ-012 SHALL have port mem_rdata  input  DATA_W  combinational read data returned by the memory.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-014 SHALL, in IDLE with any req high, choose a winner, latch its we/addr/wdata and index, and enter ACCESS at the next edge; with no req high it SHALL stay in IDLE.
REQ-015 SHALL arbitrate round-robin: when both req are high, the master not granted last wins. The last-granted pointer resets to m1, so m0 wins the first tie.
REQ-016 SHALL update the last-granted pointer only when a grant is latched.
REQ-017 SHALL, in ACCESS, drive mem_addr/mem_wdata from the latched values, assert mem_write when the latched we=1 or mem_read when we=0, and never both; all mem_* outputs SHALL be zero outside ACCESS.
REQ-018 SHALL capture mem_rdata into the winner's rdata register at the ACCESS->RESP edge for reads; for writes that rdata register SHALL keep its previous value.
REQ-019 SHALL, in RESP, assert exactly one ack (the winner's) for exactly one cycle, then return to IDLE.
REQ-020 SHALL give a latency of 2 edges from the request being sampled in IDLE to ack high; the minimum repeat interval per access SHALL be 3 cycles.
REQ-021 SHALL ignore req changes during ACCESS and RESP; the latched values govern the access.
REQ-022 SHALL treat a req still high in IDLE after its ack as a new request; the requester is responsible for deasserting req on the edge where it samples ack.
REQ-023 SHALL pass out-of-range addresses unchanged; the memory returns 0 for them, and the arbiter completes the access normally.
REQ-024 SHALL never assert m0_ack and m1_ack in the same cycle.

Reset
REQ-025 SHALL, on reset high at a clock edge, force the state to IDLE, the pointer to m1, acks to 0, mem_* to 0, and both rdata registers to 0.
REQ-026 SHALL abandon an access interrupted by reset in ACCESS without an ack; the memory write in that cycle is suppressed because mem_write is forced low during reset.
REQ-027 SHALL give reset priority over every other event on the same edge.

Structure
REQ-028 SHALL keep the state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the ADDR_W/DATA_W defaults in a shared include file used by the CPU top level.
REQ-029 SHALL place the two-way round-robin pick in a sub-module rr_pick2 with inputs req0, req1, last and outputs gnt_valid, gnt_idx; the pick is combinational.

Verification
REQ-030 m0 write addr=16, wdata=32'hDEADBEEF -> mem_write=1 and mem_addr=16 for exactly one cycle, m0_ack 2 edges after the request is sampled; a following m1 read of addr=16 -> m1_rdata=32'hDEADBEEF.
REQ-031 m0 and m1 both request reads (addr 3, addr 4) in the same cycle after reset -> m0 is served first with rdata=32'h4F, then m1 with rdata=32'h66; the acks are 3 cycles apart.
REQ-032 Both masters hold req continuously for 6 accesses -> grants alternate m0, m1, m0, ... with no master granted twice in a row.
REQ-033 m1 read of addr=30'h100 (out of range) -> m1_ack is asserted with m1_rdata=0.
REQ-034 Reset asserted during ACCESS of an m1 write to addr=20 -> no ack, mem_write low, RAM[20] unchanged, state IDLE next cycle.
REQ-035 m0 changes addr/wdata during ACCESS -> the memory sees the originally latched values.
